sync_fifo: RTL and testbench

Single-clock, first-in-first-out buffer with a registered read port.
- Status outputs: full, empty, programmable almost-full (pro_full) and programmable almost-empty (pro_empty).
- Used as a general-purpose rate/burst decoupler between two blocks in the same clock domain.
- Storage is an inferred dual-port RAM of DATA_DEPTH words.

---
 rtl/sync_fifo_pkg.sv | 17 +
 rtl/sync_fifo_if.sv | 25 ++
 rtl/sync_fifo_ram.sv | 34 +++
 rtl/sync_fifo.sv | 67 ++++++
 tb/tb_sync_fifo.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared sizing, thresholds and types for the single-clock FIFO.
// Imported by the interface, the RAM and the FIFO top.
package sync_fifo_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DATA_DEPTH = 512;
    localparam int ADDR_W     = $clog2(DATA_DEPTH);
    localparam int CNT_W      = $clog2(DATA_DEPTH + 1);

    localparam int DEF_PROG_FULL_THRESH  = DATA_DEPTH - 8;
    localparam int DEF_PROG_EMPTY_THRESH = 8;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_W-1:0]     addr_t;
    typedef logic [CNT_W-1:0]      cnt_t;

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read request bundle and status flags of the FIFO.
// master = the block using the FIFO, slave = the FIFO itself.
interface sync_fifo_if;
    import sync_fifo_pkg::*;

    data_t data_in;
    logic  wr_en;
    logic  rd_en;
    data_t data_out;
    logic  full;
    logic  empty;
    logic  pro_full;
    logic  pro_empty;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, full, empty, pro_full, pro_empty
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, full, empty, pro_full, pro_empty
    );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array has no reset; only the read register clears.
module sync_fifo_ram
    import sync_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  we,
    input  addr_t waddr,
    input  data_t wdata,
    input  logic  re,
    input  addr_t raddr,
    output data_t rdata
);

    data_t mem [DATA_DEPTH];

    // Store the word on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register only moves on an accepted read, so it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count and status flags.
// Storage and the registered read port live in sync_fifo_ram.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int PROG_FULL_THRESH  = DEF_PROG_FULL_THRESH,
    parameter int PROG_EMPTY_THRESH = DEF_PROG_EMPTY_THRESH
) (
    input  logic         clk,
    input  logic         rst_n,
    sync_fifo_if.slave   bus
);

    addr_t wr_ptr;
    addr_t rd_ptr;
    cnt_t  count;
    logic  wr_acc;
    logic  rd_acc;

    // Accept decisions use the flags as they stood before the edge.
    always_comb begin
        wr_acc = bus.wr_en && !bus.full;
        rd_acc = bus.rd_en && !bus.empty;
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + addr_t'(1);
            if (rd_acc) rd_ptr <= rd_ptr + addr_t'(1);
        end
    end

    // Occupancy moves only when exactly one side is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_acc && !rd_acc) begin
            count <= count + cnt_t'(1);
        end else if (rd_acc && !wr_acc) begin
            count <= count - cnt_t'(1);
        end
    end

    // Flags decode straight off the count register.
    always_comb begin
        bus.full      = (count == cnt_t'(DATA_DEPTH));
        bus.empty     = (count == '0);
        bus.pro_full  = (count >= cnt_t'(PROG_FULL_THRESH));
        bus.pro_empty = (count <= cnt_t'(PROG_EMPTY_THRESH));
    end

    sync_fifo_ram u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (bus.data_out)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised + directed bench for sync_fifo against a queue model.
// Model: a queue of accepted words and the last word read out.
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    logic clk;
    logic rst_n;

    sync_fifo_if bus ();

    sync_fifo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    data_t q [$];
    data_t exp_dout;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, report a mismatch.
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Compare every output against what the model implies.
    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ".dout"}, bus.data_out, exp_dout);
        check({tag, ".full"}, 32'(bus.full), 32'(n == DATA_DEPTH));
        check({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
        check({tag, ".pfull"}, 32'(bus.pro_full),
              32'(n >= DEF_PROG_FULL_THRESH));
        check({tag, ".pempty"}, 32'(bus.pro_empty),
              32'(n <= DEF_PROG_EMPTY_THRESH));
    endtask

    // One clock with the given requests, then model update and checks.
    task automatic cyc(input string tag, input logic w, input logic r,
                       input data_t d);
        logic wa, ra;
        bus.wr_en   = w;
        bus.rd_en   = r;
        bus.data_in = d;
        wa = w && (q.size() < DATA_DEPTH);
        ra = r && (q.size() != 0);
        @(posedge clk);
        if (ra) exp_dout = q.pop_front();
        if (wa) q.push_back(d);
        #1;
        check_all(tag);
    endtask

    initial begin
        data_t v;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        exp_dout    = '0;

        // 1. reset
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;
        #1;
        check_all("reset");
        cyc("rd_empty", 1'b0, 1'b1, '0);
        cyc("idle", 1'b0, 1'b0, '0);

        // 2. fill, plus one dropped write
        for (int i = 0; i < DATA_DEPTH; i++)
            cyc("fill", 1'b1, 1'b0, data_t'(512 + i));
        cyc("wr_full", 1'b1, 1'b0, 32'hDEAD);
        check("full_hold", 32'(q.size()), 32'd512);

        // 3. drain with rd_en held well past empty
        for (int i = 0; i < 1000; i++)
            cyc("drain", 1'b0, 1'b1, '0);
        check("drain_last", bus.data_out, 32'd1023);

        // 4. wrap across index 511 -> 0
        for (int i = 0; i < DATA_DEPTH; i++)
            cyc("wrap_w", 1'b1, 1'b0, data_t'(100 + i));
        for (int i = 0; i < DATA_DEPTH + 2; i++)
            cyc("wrap_r", 1'b0, 1'b1, '0);
        check("wrap_last", bus.data_out, 32'd611);

        // 5. simultaneous read/write, mid-level then full
        for (int i = 0; i < 10; i++)
            cyc("pre", 1'b1, 1'b0, data_t'(2000 + i));
        for (int i = 0; i < 20; i++)
            cyc("simul", 1'b1, 1'b1, data_t'(3000 + i));
        check("simul_cnt", 32'(q.size()), 32'd10);
        while (q.size() < DATA_DEPTH)
            cyc("refill", 1'b1, 1'b0, $urandom);
        cyc("simul_full", 1'b1, 1'b1, 32'hBEEF);
        check("full_drop", 32'(bus.full), 32'd0);
        cyc("refull", 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 3; i++)
            cyc("simul_f2", 1'b1, 1'b1, $urandom);

        // 6. async reset mid-stream at count 300
        while (q.size() > 300)
            cyc("to300", 1'b0, 1'b1, '0);
        check("cnt300", 32'(q.size()), 32'd300);
        cyc("rd_once", 1'b1, 1'b1, 32'h1234_5678);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_dout = '0;
        check_all("async_rst");
        #1;
        rst_n = 1'b1;
        cyc("post_rst", 1'b0, 1'b1, '0);

        // random phase with varying write/read bias
        for (int i = 0; i < 6000; i++) begin
            int wp, rp;
            wp = (i / 1000) % 2 == 0 ? 70 : 30;
            rp = 100 - wp;
            v  = $urandom;
            cyc("rand", 1'($urandom_range(99) < wp),
                1'($urandom_range(99) < rp), v);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
